// File: rtl/autotune_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | autotune_pkg: shared types and note-period table for the autotune path     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package autotune_pkg;

  localparam int PERIOD_W    = 12;
  localparam int NUM_PERIODS = 48;

  // Table terminator; above every legal search key so the scan always stops.
  localparam logic [PERIOD_W-1:0] SENTINEL = '1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    IDLE   = 2'd1,
    SEARCH = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  // Equal-tempered periods at 48 kHz, B5 down to C2 (A4 = 109), ascending.
  localparam logic [PERIOD_W-1:0] NOTE_PERIODS [NUM_PERIODS] = '{
    12'd49,  12'd51,  12'd55,  12'd58,  12'd61,  12'd65,  12'd69,  12'd73,
    12'd77,  12'd82,  12'd87,  12'd92,  12'd97,  12'd103, 12'd109, 12'd116,
    12'd122, 12'd130, 12'd137, 12'd146, 12'd154, 12'd163, 12'd173, 12'd183,
    12'd194, 12'd206, 12'd218, 12'd231, 12'd245, 12'd259, 12'd275, 12'd291,
    12'd309, 12'd327, 12'd346, 12'd367, 12'd389, 12'd412, 12'd436, 12'd462,
    12'd490, 12'd519, 12'd550, 12'd582, 12'd617, 12'd654, 12'd693, 12'd734
  };

endpackage
`default_nettype wire

// File: rtl/note_search_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_search_sequencer_if: store/search port to the closest-note searcher   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface note_search_sequencer_if #(
  parameter int WIDTH = 12
);
  logic             valid_store_val;
  logic [WIDTH-1:0] to_store_val;
  logic             searching;
  logic [WIDTH-1:0] search_val;
  logic [WIDTH-1:0] closest_value;
  logic             closest_value_found;

  modport master (
    output valid_store_val, to_store_val, searching, search_val,
    input  closest_value, closest_value_found
  );

  modport slave (
    input  valid_store_val, to_store_val, searching, search_val,
    output closest_value, closest_value_found
  );
endinterface
`default_nettype wire

// File: rtl/note_period_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_period_rom: combinational index-to-period lookup; 0 past the table    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module note_period_rom
  import autotune_pkg::*;
#(
  parameter int WIDTH     = PERIOD_W,
  parameter int NUM_NOTES = NUM_PERIODS,
  parameter int IDX_W     = $clog2(NUM_NOTES + 1)
) (
  input  wire  [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] period_o
);

  always_comb begin
    period_o = '0;
    if (int'(idx_i) < NUM_NOTES) begin
      period_o = NOTE_PERIODS[idx_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/note_search_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_search_sequencer: loads the note table into the searcher, then runs   |
// | one search per voiced period estimate. Option: NOTE_SEQ_STATS_EN counters. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module note_search_sequencer
  import autotune_pkg::*;
#(
  parameter int WIDTH     = PERIOD_W,
  parameter int NUM_NOTES = NUM_PERIODS
) (
  input  wire                     clk_in,
  input  wire                     rst_in,
  input  wire                     period_valid,
  input  wire  [WIDTH-1:0]        period_in,
  note_search_sequencer_if.master srch,
  output logic                    table_loaded,
  output logic                    target_valid,
  output logic [WIDTH-1:0]        target_period,
  output logic [WIDTH-1:0]        detected_period
`ifdef NOTE_SEQ_STATS_EN
  ,
  output logic [15:0]             search_count,
  output logic [15:0]             drop_count
`endif
);

  localparam int               IDX_W    = $clog2(NUM_NOTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES);
  localparam logic [WIDTH-1:0] KEY_MAX  = {{(WIDTH-1){1'b1}}, 1'b0};

  seq_state_t       state_q, state_d;
  logic             phase_q;
  logic [IDX_W-1:0] load_idx_q, load_idx_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] detected_q, detected_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             target_valid_q, target_valid_d;
  logic             loaded_q, loaded_d;
  logic [WIDTH-1:0] rom_period;
  logic             loading;

  note_period_rom #(
    .WIDTH     (WIDTH),
    .NUM_NOTES (NUM_NOTES),
    .IDX_W     (IDX_W)
  ) u_rom (
    .idx_i    (load_idx_q),
    .period_o (rom_period)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= LOAD;
      phase_q        <= 1'b0;
      load_idx_q     <= '0;
      key_q          <= '0;
      detected_q     <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      loaded_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= ~phase_q;
      load_idx_q     <= load_idx_d;
      key_q          <= key_d;
      detected_q     <= detected_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      loaded_q       <= loaded_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_idx_d     = load_idx_q;
    key_d          = key_q;
    detected_d     = detected_q;
    target_d       = target_q;
    target_valid_d = 1'b0;
    loaded_d       = loaded_q;
    case (state_q)
      LOAD: begin
        // Each word spans an even/odd phase pair; advance after the odd half.
        if (phase_q) begin
          if (load_idx_q == LAST_IDX) begin
            state_d  = IDLE;
            loaded_d = 1'b1;
          end else begin
            load_idx_d = load_idx_q + 1'b1;
          end
        end
      end
      IDLE: begin
        if (period_valid && (period_in != '0)) begin
          key_d      = (period_in > KEY_MAX) ? KEY_MAX : period_in;
          detected_d = period_in;
          state_d    = SEARCH;
        end
      end
      SEARCH: begin
        if (srch.closest_value_found) begin
          target_d       = srch.closest_value;
          target_valid_d = 1'b1;
          state_d        = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for the searcher to clear its result before accepting a new key.
        if (!srch.closest_value_found) begin
          state_d = IDLE;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Reset gating keeps the store port quiet while rst_in holds the FSM in LOAD.
  assign loading              = (state_q == LOAD) && !rst_in;
  assign srch.valid_store_val = loading;
  assign srch.to_store_val    = !loading                 ? '0 :
                                (load_idx_q == LAST_IDX) ? SENTINEL : rom_period;
  assign srch.searching       = (state_q == SEARCH);
  assign srch.search_val      = key_q;

  assign table_loaded    = loaded_q;
  assign target_valid    = target_valid_q;
  assign target_period   = target_q;
  assign detected_period = detected_q;

`ifdef NOTE_SEQ_STATS_EN
  logic [15:0] search_count_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      search_count_q <= '0;
      drop_count_q   <= '0;
    end else begin
      if (target_valid_q && (search_count_q != 16'hFFFF)) begin
        search_count_q <= search_count_q + 16'd1;
      end
      if (period_valid && (period_in != '0) && (state_q != IDLE) &&
          (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  assign search_count = search_count_q;
  assign drop_count   = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_note_search_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_note_search_sequencer: sequencer driving a behavioural searcher, with a |
// | nearest-note reference model and a result scoreboard.                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_note_search_sequencer;

  localparam int W       = 12;
  localparam int LAT_MAX = 2 * (48 + 2) + 4;

  int REF_PERIODS [48] = '{
    49,  51,  55,  58,  61,  65,  69,  73,  77,  82,  87,  92,
    97,  103, 109, 116, 122, 130, 137, 146, 154, 163, 173, 183,
    194, 206, 218, 231, 245, 259, 275, 291, 309, 327, 346, 367,
    389, 412, 436, 462, 490, 519, 550, 582, 617, 654, 693, 734
  };

  typedef struct {
    int target;
    int detected;
    int issued;
  } exp_t;

  logic         clk_in;
  logic         rst_in;
  logic         period_valid;
  logic [W-1:0] period_in;
  logic         table_loaded;
  logic         target_valid;
  logic [W-1:0] target_period;
  logic [W-1:0] detected_period;
`ifdef NOTE_SEQ_STATS_EN
  logic [15:0]  search_count;
  logic [15:0]  drop_count;
`endif

  note_search_sequencer_if #(.WIDTH(W)) srch ();

  note_search_sequencer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .period_valid    (period_valid),
    .period_in       (period_in),
    .srch            (srch),
    .table_loaded    (table_loaded),
    .target_valid    (target_valid),
    .target_period   (target_period),
    .detected_period (detected_period)
`ifdef NOTE_SEQ_STATS_EN
    ,
    .search_count    (search_count),
    .drop_count      (drop_count)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_popped = 0;
  int   search_starts = 0;
  int   last_strobe_cyc = 0;
  int   exp_search = 0;
  int   exp_drop = 0;
  exp_t sb[$];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Behavioural closest-note searcher: samples on even phases, one entry per sample.
  bit s_phase;
  int s_wr;
  int s_idx;
  int s_mem [64];

  function automatic int snap_at(input int j, input int key);
    if (j == 0) return s_mem[0];
    if (s_mem[j] == 4095) return s_mem[j-1];
    if ((key - s_mem[j-1]) <= (s_mem[j] - key)) return s_mem[j-1];
    return s_mem[j];
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_phase                  <= 1'b0;
      s_wr                     <= 0;
      s_idx                    <= 0;
      srch.closest_value_found <= 1'b0;
      srch.closest_value       <= '0;
    end else begin
      s_phase <= ~s_phase;
      if (!s_phase) begin
        if (srch.valid_store_val && s_wr < 64) begin
          s_mem[s_wr] <= int'(srch.to_store_val);
          s_wr        <= s_wr + 1;
        end
        if (!srch.searching) begin
          s_idx                    <= 0;
          srch.closest_value_found <= 1'b0;
        end else if (!srch.closest_value_found) begin
          if (s_mem[s_idx] >= int'(srch.search_val) || s_idx >= 63) begin
            srch.closest_value_found <= 1'b1;
            srch.closest_value       <= W'(snap_at(s_idx, int'(srch.search_val)));
          end else begin
            s_idx <= s_idx + 1;
          end
        end
      end
    end
  end

  // Reference: nearest table entry to the clamped key, lower entry on a tie.
  function automatic int ref_snap(input int p);
    int key;
    int best;
    key  = (p > 4094) ? 4094 : p;
    best = REF_PERIODS[0];
    foreach (REF_PERIODS[i]) begin
      int d_new, d_best;
      d_new  = (REF_PERIODS[i] > key) ? REF_PERIODS[i] - key : key - REF_PERIODS[i];
      d_best = (best > key) ? best - key : key - best;
      if (d_new < d_best) best = REF_PERIODS[i];
    end
    return best;
  endfunction

  // Result monitor / scoreboard.
  bit prev_searching = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    int   lat;
    if (!rst_in) begin
      if (srch.searching && !prev_searching) begin
        search_starts++;
        check("search_start_found_clear", int'(srch.closest_value_found), 0);
      end
      prev_searching = srch.searching;
      if (target_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_target: actual target_period=%0d required no target_valid",
                   target_period);
        end else begin
          e = sb.pop_front();
          check("target_period", int'(target_period), e.target);
          check("detected_period", int'(detected_period), e.detected);
          lat = cyc - e.issued;
          n_cmp++;
          if (lat > LAT_MAX) begin
            n_bad++;
            $display("FAIL latency: actual=%0d cycles required<=%0d", lat, LAT_MAX);
          end
          n_popped++;
        end
      end
    end else begin
      prev_searching = 1'b0;
    end
  end

  task automatic strobe(input int p);
    @(posedge clk_in);
    #1;
    period_valid    = 1'b1;
    period_in       = W'(p);
    last_strobe_cyc = cyc;
    @(posedge clk_in);
    #1;
    period_valid = 1'b0;
    period_in    = '0;
  endtask

  task automatic issue(input int p);
    exp_t e;
    strobe(p);
    if (p != 0) begin
      e.target   = ref_snap(p);
      e.detected = p;
      e.issued   = last_strobe_cyc;
      sb.push_back(e);
      exp_search++;
    end
  endtask

  task automatic wait_idle();
    int start;
    int k;
    start = n_popped;
    k     = 0;
    while (n_popped == start && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    if (n_popped == start) check("result_timeout", 0, 1);
    k = 0;
    while (srch.closest_value_found && k < 50) begin
      @(negedge clk_in);
      k++;
    end
    if (srch.closest_value_found) check("found_clear_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_store_val"}, int'(srch.valid_store_val), 0);
    check({tag, "_to_store_val"}, int'(srch.to_store_val), 0);
    check({tag, "_searching"}, int'(srch.searching), 0);
    check({tag, "_search_val"}, int'(srch.search_val), 0);
    check({tag, "_table_loaded"}, int'(table_loaded), 0);
    check({tag, "_target_valid"}, int'(target_valid), 0);
    check({tag, "_target_period"}, int'(target_period), 0);
    check({tag, "_detected_period"}, int'(detected_period), 0);
`ifdef NOTE_SEQ_STATS_EN
    check({tag, "_search_count"}, int'(search_count), 0);
    check({tag, "_drop_count"}, int'(drop_count), 0);
`endif
  endtask

  task automatic check_stats(input string tag);
`ifdef NOTE_SEQ_STATS_EN
    check({tag, "_search_count"}, int'(search_count), exp_search);
    check({tag, "_drop_count"}, int'(drop_count), exp_drop);
`endif
  endtask

  // Starts in the first cycle after reset release.
  task automatic load_check();
    int word;
    for (int c = 0; c < 99; c++) begin
      @(negedge clk_in);
      if (c < 98) begin
        word = (c / 2 < 48) ? REF_PERIODS[c / 2] : 4095;
        check("load_store_valid", int'(srch.valid_store_val), 1);
        check("load_store_word", int'(srch.to_store_val), word);
        check("load_table_loaded_low", int'(table_loaded), 0);
      end else begin
        check("load_store_valid_end", int'(srch.valid_store_val), 0);
        check("load_table_loaded_high", int'(table_loaded), 1);
        check("load_write_count", s_wr, 49);
      end
    end
  endtask

  initial begin
    repeat (50000) @(posedge clk_in);
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    rst_in       = 1'b1;
    period_valid = 1'b0;
    period_in    = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("reset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    load_check();

    // Nominal snap with a second estimate arriving mid-search.
    issue(110);
    strobe(200);
    exp_drop++;
    wait_idle();
    check_stats("busy_drop");

    // Unvoiced estimate is ignored.
    st = search_starts;
    issue(0);
    repeat (10) @(negedge clk_in);
    check("unvoiced_search_starts", search_starts - st, 0);

    // Clamp to one below the sentinel.
    issue(4095);
    @(negedge clk_in);
    check("clamp_searching", int'(srch.searching), 1);
    check("clamp_search_val", int'(srch.search_val), 4094);
    wait_idle();

    // Back-to-back at the first IDLE cycle.
    issue(109);
    wait_idle();
    issue(300);
    wait_idle();

    // Randomised traffic with occasional busy strobes.
    for (int n = 0; n < 25; n++) begin
      int p;
      int sel;
      int dp;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       p = 0;
        1:       p = $urandom_range(4000, 4095);
        2:       p = $urandom_range(1, 48);
        default: p = $urandom_range(49, 760);
      endcase
      if (p == 0) begin
        st = search_starts;
        issue(0);
        repeat (6) @(negedge clk_in);
        check("rand_unvoiced_starts", search_starts - st, 0);
      end else begin
        issue(p);
        if ($urandom_range(0, 1) == 1) begin
          dp = $urandom_range(0, 800);
          strobe(dp);
          if (dp != 0) exp_drop++;
        end
        wait_idle();
      end
      repeat ($urandom_range(0, 3)) @(posedge clk_in);
    end
    check_stats("random");

    // Reset three cycles into a search.
    issue(500);
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    check("pre_reset_searching", int'(srch.searching), 1);
    rst_in = 1'b1;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    exp_search = 0;
    exp_drop   = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    load_check();
    issue(200);
    wait_idle();
    check_stats("after_reload");

    repeat (5) @(negedge clk_in);
    check("scoreboard_empty", sb.size(), 0);
    check("table_loaded_held", int'(table_loaded), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
